// File: rtl/dmg_pkg.sv
// rtl/dmg_pkg.sv - DMG geometry, VRAM address layout and pixel types shared by sampler and scanout
package dmg_pkg;

    localparam int DMG_H_ACTIVE = 160;
    localparam int DMG_V_ACTIVE = 144;

    typedef logic [1:0]  pixel_t;
    typedef logic [15:0] cnt_t;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] x;
    } vram_addr_t;

    typedef enum logic [1:0] {
        SCAN_ACTIVE,
        SCAN_HBLANK,
        SCAN_VBLANK
    } scan_state_t;

    function automatic vram_addr_t vram_addr(input logic [7:0] y, input logic [7:0] x);
        vram_addr_t a;
        a.y = y;
        a.x = x;
        return a;
    endfunction

endpackage

// File: rtl/dmg_lcd_scanout_if.sv
// rtl/dmg_lcd_scanout_if.sv - VRAM read port plus DMG LCD panel signals
interface dmg_lcd_scanout_if;

    logic [15:0]     vram_rdaddr;
    dmg_pkg::pixel_t vram_rddata;
    logic            lcd_cp;
    dmg_pkg::pixel_t lcd_data;
    logic            lcd_cpl;
    logic            lcd_st;
    logic            lcd_s;
    logic            lcd_fr;
    logic            frame_start;

    modport master (
        output vram_rdaddr, lcd_cp, lcd_data, lcd_cpl, lcd_st, lcd_s, lcd_fr, frame_start,
        input  vram_rddata
    );

    modport slave (
        input  vram_rdaddr, lcd_cp, lcd_data, lcd_cpl, lcd_st, lcd_s, lcd_fr, frame_start,
        output vram_rddata
    );

endinterface

// File: rtl/dmg_lcd_timing.sv
// rtl/dmg_lcd_timing.sv - phase/pixel/line counters and ACTIVE/HBLANK/VBLANK decode
module dmg_lcd_timing
    import dmg_pkg::*;
#(
    parameter int H_ACTIVE = DMG_H_ACTIVE,
    parameter int V_ACTIVE = DMG_V_ACTIVE,
    parameter int H_BLANK  = 8,
    parameter int V_BLANK  = 10,
    parameter int CP_DIV   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    output cnt_t        o_phase,
    output cnt_t        o_px,
    output cnt_t        o_line,
    output scan_state_t o_state
);

    localparam cnt_t PH_LAST = cnt_t'(2 * CP_DIV - 1);
    localparam cnt_t PX_LAST = cnt_t'(H_ACTIVE + H_BLANK - 1);
    localparam cnt_t LN_LAST = cnt_t'(V_ACTIVE + V_BLANK - 1);
    localparam cnt_t HA      = cnt_t'(H_ACTIVE);
    localparam cnt_t VA      = cnt_t'(V_ACTIVE);

    cnt_t r_phase, r_px, r_line;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= '0;
            r_px    <= '0;
            r_line  <= '0;
        end else if (!i_en) begin
            r_phase <= '0;
            r_px    <= '0;
            r_line  <= '0;
        end else if (r_phase == PH_LAST) begin
            r_phase <= '0;
            if (r_px == PX_LAST) begin
                r_px   <= '0;
                r_line <= (r_line == LN_LAST) ? '0 : r_line + 16'd1;
            end else begin
                r_px <= r_px + 16'd1;
            end
        end else begin
            r_phase <= r_phase + 16'd1;
        end
    end

    always_comb begin
        o_state = SCAN_VBLANK;
        if (r_line < VA) begin
            o_state = (r_px < HA) ? SCAN_ACTIVE : SCAN_HBLANK;
        end
    end

    assign o_phase = r_phase;
    assign o_px    = r_px;
    assign o_line  = r_line;

endmodule

// File: rtl/dmg_lcd_scanout.sv
// rtl/dmg_lcd_scanout.sv - scans a 2bpp VRAM window out to the DMG LCD panel interface
module dmg_lcd_scanout
    import dmg_pkg::*;
#(
    parameter int         H_ACTIVE = DMG_H_ACTIVE,
    parameter int         V_ACTIVE = DMG_V_ACTIVE,
    parameter int         H_BLANK  = 8,
    parameter int         V_BLANK  = 10,
    parameter int         CP_DIV   = 4,
    parameter logic [7:0] X_OFFSET = 8'h00,
    parameter logic [7:0] Y_OFFSET = 8'h00
) (
    input  logic                i_vramclk,
    input  logic                i_rst_n,
    input  logic                i_disp_en,
    dmg_lcd_scanout_if.master   bus
);

    localparam cnt_t HA      = cnt_t'(H_ACTIVE);
    localparam cnt_t VA      = cnt_t'(V_ACTIVE);
    localparam cnt_t CP_HALF = cnt_t'(CP_DIV);

    cnt_t        w_phase, w_px, w_line;
    scan_state_t w_state;
    logic        w_active, w_visible, w_pos0, w_cpl;

    vram_addr_t r_rdaddr;
    pixel_t     r_lcd_data;
    logic       r_lcd_cp, r_lcd_cpl, r_lcd_st, r_lcd_s, r_lcd_fr, r_frame_start;
    logic       r_started, r_wrapped;

    dmg_lcd_timing #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_BLANK  (V_BLANK),
        .CP_DIV   (CP_DIV)
    ) u_timing (
        .i_clk   (i_vramclk),
        .i_rst_n (i_rst_n),
        .i_en    (i_disp_en),
        .o_phase (w_phase),
        .o_px    (w_px),
        .o_line  (w_line),
        .o_state (w_state)
    );

    assign w_active  = (w_state == SCAN_ACTIVE);
    assign w_visible = (w_state != SCAN_VBLANK);
    assign w_pos0    = (w_phase == '0) && (w_px == '0) && (w_line == '0);

    // Without horizontal blanking the latch moves to px 0 of the line after each visible one.
    always_comb begin
        w_cpl = 1'b0;
        if (H_BLANK > 0) begin
            w_cpl = w_visible && (w_px == HA);
        end else if (w_px == '0) begin
            w_cpl = (w_line == '0) ? ((V_BLANK == 0) && r_wrapped) : (w_line <= VA);
        end
    end

    always_ff @(posedge i_vramclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdaddr      <= '0;
            r_lcd_data    <= '0;
            r_lcd_cp      <= 1'b0;
            r_lcd_cpl     <= 1'b0;
            r_lcd_st      <= 1'b0;
            r_lcd_s       <= 1'b0;
            r_lcd_fr      <= 1'b0;
            r_frame_start <= 1'b0;
            r_started     <= 1'b0;
            r_wrapped     <= 1'b0;
        end else if (!i_disp_en) begin
            r_rdaddr      <= '0;
            r_lcd_data    <= '0;
            r_lcd_cp      <= 1'b0;
            r_lcd_cpl     <= 1'b0;
            r_lcd_st      <= 1'b0;
            r_lcd_s       <= 1'b0;
            r_lcd_fr      <= 1'b0;
            r_frame_start <= 1'b0;
            r_started     <= 1'b0;
            r_wrapped     <= 1'b0;
        end else begin
            r_started     <= 1'b1;
            r_frame_start <= w_pos0;
            // The first position after enable starts a frame but is not a wrap.
            if (w_pos0 && r_started) begin
                r_lcd_fr  <= ~r_lcd_fr;
                r_wrapped <= 1'b1;
            end
            r_lcd_st  <= w_visible && (w_px == '0);
            r_lcd_cpl <= w_cpl;
            r_lcd_s   <= (w_line == '0);
            r_lcd_cp  <= w_active && (w_phase >= CP_HALF);
            if (w_active && (w_phase == '0)) begin
                r_rdaddr <= vram_addr(Y_OFFSET + w_line[7:0], X_OFFSET + w_px[7:0]);
            end
            if (!w_visible) begin
                r_lcd_data <= '0;
            end else if (w_active && (w_phase == 16'd2)) begin
                r_lcd_data <= bus.vram_rddata;
            end
        end
    end

    assign bus.vram_rdaddr = r_rdaddr;
    assign bus.lcd_cp      = r_lcd_cp;
    assign bus.lcd_data    = r_lcd_data;
    assign bus.lcd_cpl     = r_lcd_cpl;
    assign bus.lcd_st      = r_lcd_st;
    assign bus.lcd_s       = r_lcd_s;
    assign bus.lcd_fr      = r_lcd_fr;
    assign bus.frame_start = r_frame_start;

endmodule
